am_bip_inserter: RTL and testbench

Transmit-side counterpart of the receive-side BIP error counter for one PCS lane. The block accepts 66-bit blocks from the lane distributor, counts them, and every AM_PERIOD data blocks inserts a per-lane alignment marker. The marker carries BIP3/BIP7, computed over every bit sent on the lane since the previous marker, so the far end can count bit errors. It sits between block distribution and the lane serializer and applies backpressure for exactly one cycle per insertion.

---
 rtl/am_bip_inserter.sv | 124 ++++++++++++
 tb/tb_am_bip_inserter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/am_bip_inserter.sv
// am_bip_inserter: per-lane alignment marker insertion with running BIP.
// Forwards 66-bit blocks from the lane distributor. Every AM_PERIOD data blocks it
// stalls upstream for one cycle and emits an alignment marker. The marker carries
// the BIP of everything sent on the lane since the previous marker.
//
// Handshake: a transfer happens on a cycle where i_valid && o_ready. o_ready depends
// only on the current state. Upstream may raise or drop i_valid at any time. A block
// offered while o_ready is low is not consumed and must be held or re-offered.
// o_valid marks each cycle whose o_data/o_am_flag is new. The downstream serializer
// never stalls, so there is no ready input on the output side.
module am_bip_inserter #(
    parameter int         NB_DATA   = 66,
    parameter int         AM_PERIOD = 16383,
    parameter logic [7:0] LANE_M0   = 8'hC1,
    parameter logic [7:0] LANE_M1   = 8'h68,
    parameter logic [7:0] LANE_M2   = 8'h21
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_ready,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_am_flag
);

    localparam int             CNT_W    = $clog2(AM_PERIOD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AM_PERIOD - 1);
    // A marker's own BIP contribution is fixed. The four byte/complement pairs
    // cancel to 8'h00, and sync header bit 0 flips bip[3].
    localparam logic [7:0]     MARKER_BIP = 8'h08;

    typedef enum logic {
        ST_INSERT = 1'b0,
        ST_PASS   = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic [7:0]         acc_q, acc_d;
    logic               valid_q, valid_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic               am_flag_q, am_flag_d;
    logic [NB_DATA-1:0] marker;

    // Byte-wise XOR of the 8 payload bytes. Sync header bits fold into bip[3] and bip[4].
    function automatic logic [7:0] blk_bip(input logic [NB_DATA-1:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < 8; k++) begin
            r = r ^ b[2 + 8*k +: 8];
        end
        r[3] = r[3] ^ b[0];
        r[4] = r[4] ^ b[1];
        return r;
    endfunction

    // Marker block: control sync header, then M0 M1 M2 BIP3 ~M0 ~M1 ~M2 ~BIP3 (byte 0 first).
    assign marker = {~acc_q, ~LANE_M2, ~LANE_M1, ~LANE_M0,
                     acc_q, LANE_M2, LANE_M1, LANE_M0, 2'b01};

    // Next-state, counter, accumulator and output-register computation.
    always_comb begin
        state_d   = state_q;
        blk_cnt_d = blk_cnt_q;
        acc_d     = acc_q;
        valid_d   = 1'b0;
        data_d    = data_q;
        am_flag_d = am_flag_q;
        case (state_q)
            ST_INSERT: begin
                // Marker goes out without waiting for upstream.
                valid_d   = 1'b1;
                am_flag_d = 1'b1;
                data_d    = marker;
                acc_d     = MARKER_BIP;
                state_d   = ST_PASS;
            end
            ST_PASS: begin
                if (i_valid) begin
                    valid_d   = 1'b1;
                    am_flag_d = 1'b0;
                    data_d    = i_data;
                    acc_d     = acc_q ^ blk_bip(i_data);
                    if (blk_cnt_q == CNT_LAST) begin
                        blk_cnt_d = '0;
                        state_d   = ST_INSERT;
                    end else begin
                        blk_cnt_d = blk_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_INSERT;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= ST_INSERT;
            blk_cnt_q <= '0;
            acc_q     <= 8'h00;
            valid_q   <= 1'b0;
            data_q    <= '0;
            am_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            blk_cnt_q <= blk_cnt_d;
            acc_q     <= acc_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            am_flag_q <= am_flag_d;
        end
    end

    assign o_ready   = (state_q == ST_PASS);
    assign o_valid   = valid_q;
    assign o_data    = data_q;
    assign o_am_flag = am_flag_q;

endmodule

// File: tb/tb_am_bip_inserter.sv
// Bench for am_bip_inserter. Two instances (AM_PERIOD 4 and 3) share one stimulus stream.
module tb_am_bip_inserter;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_valid = 1'b0;
  logic [65:0] i_data = '0;

  logic        rdy0, ov0, fl0;
  logic [65:0] od0;
  logic        rdy1, ov1, fl1;
  logic [65:0] od1;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state, index 0 = period 4, index 1 = period 3
  int          m_per[2] = '{4, 3};
  logic        m_ins[2];
  int          m_cnt[2];
  logic [7:0]  m_acc[2];
  logic [66:0] last_out[2];
  logic [66:0] exp_q0[$];
  logic [66:0] exp_q1[$];

  always #5 clk = ~clk;

  am_bip_inserter #(.NB_DATA(66), .AM_PERIOD(4)) u_dut0 (
    .i_clock(clk), .i_reset(i_reset), .i_valid(i_valid), .i_data(i_data),
    .o_ready(rdy0), .o_valid(ov0), .o_data(od0), .o_am_flag(fl0)
  );

  am_bip_inserter #(.NB_DATA(66), .AM_PERIOD(3)) u_dut1 (
    .i_clock(clk), .i_reset(i_reset), .i_valid(i_valid), .i_data(i_data),
    .o_ready(rdy1), .o_valid(ov1), .o_data(od1), .o_am_flag(fl1)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [65:0] mk_marker(input logic [7:0] bip);
    logic [7:0] m0, m1, m2;
    m0 = 8'hC1; m1 = 8'h68; m2 = 8'h21;
    return {~bip, ~m2, ~m1, ~m0, bip, m2, m1, m0, 2'b01};
  endfunction

  function automatic logic [7:0] blk_bip(input logic [65:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < 8; k++) r = r ^ b[2 + 8*k +: 8];
    r[3] = r[3] ^ b[0];
    r[4] = r[4] ^ b[1];
    return r;
  endfunction

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_ins[n] = 1'b1;
      m_cnt[n] = 0;
      m_acc[n] = 8'h00;
      last_out[n] = '0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // advance one model by one cycle and push what it should emit
  task automatic model_step(input int n, input logic v, input logic [65:0] d);
    logic [66:0] e;
    logic push;
    push = 1'b0;
    e = '0;
    if (m_ins[n]) begin
      e = {1'b1, mk_marker(m_acc[n])};
      push = 1'b1;
      m_acc[n] = 8'h08;
      m_ins[n] = 1'b0;
    end else if (v) begin
      e = {1'b0, d};
      push = 1'b1;
      m_acc[n] = m_acc[n] ^ blk_bip(d);
      m_cnt[n]++;
      if (m_cnt[n] == m_per[n]) begin
        m_cnt[n] = 0;
        m_ins[n] = 1'b1;
      end
    end
    if (push) begin
      if (n == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
    end
  endtask

  task automatic check_out(input int n, input logic ov, input logic fl, input logic [65:0] od);
    logic [66:0] e;
    if (ov) begin
      if ((n == 0 && exp_q0.size() == 0) || (n == 1 && exp_q1.size() == 0)) begin
        chk($sformatf("spurious_valid%0d", n), {fl, od}, '0);
        if ({fl, od} == '0) begin
          n_errors++;
          $display("FAIL spurious_valid%0d act=1 exp=0", n);
        end
      end else begin
        if (n == 0) e = exp_q0.pop_front();
        else e = exp_q1.pop_front();
        chk($sformatf("out%0d", n), {fl, od}, e);
        last_out[n] = e;
      end
    end else begin
      chk($sformatf("hold%0d", n), {fl, od}, last_out[n]);
    end
  endtask

  // one clock cycle: drive inputs, check ready, step models, check outputs at negedge
  task automatic cycle(input logic v, input logic [65:0] d);
    i_valid = v;
    i_data  = d;
    #1;
    chk("ready0", {66'h0, rdy0}, {66'h0, ~m_ins[0]});
    chk("ready1", {66'h0, rdy1}, {66'h0, ~m_ins[1]});
    model_step(0, v, d);
    model_step(1, v, d);
    @(posedge clk);
    @(negedge clk);
    check_out(0, ov0, fl0, od0);
    check_out(1, ov1, fl1, od1);
  endtask

  task automatic do_reset(input logic v);
    i_reset = 1'b1;
    i_valid = v;
    i_data  = 66'h2;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("rst_out0", {ov0, fl0, rdy0, od0[63:0]}, '0);
    chk("rst_hi0", {65'h0, od0[65:64]}, '0);
    chk("rst_out1", {ov1, fl1, rdy1, od1[63:0]}, '0);
    i_reset = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic [65:0] d;
    logic        rdy;
    logic        ov;
    logic        fl;
    logic [65:0] od;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [65:0] d0, d1, rd;
    logic [95:0] r96;
    int lows0, lows1, nmk;

    d0 = 66'h2;
    d1 = {56'h0, 8'h01, 2'b10};
    // period-4 instance, from reset release
    tbl[0]  = '{1'b1, d0, 1'b0, 1'b1, 1'b1, mk_marker(8'h00)};
    tbl[1]  = '{1'b1, d0, 1'b1, 1'b1, 1'b0, d0};
    tbl[2]  = '{1'b1, d0, 1'b1, 1'b1, 1'b0, d0};
    tbl[3]  = '{1'b1, d0, 1'b1, 1'b1, 1'b0, d0};
    tbl[4]  = '{1'b1, d0, 1'b1, 1'b1, 1'b0, d0};
    tbl[5]  = '{1'b1, d0, 1'b0, 1'b1, 1'b1, mk_marker(8'h08)};
    tbl[6]  = '{1'b1, d1, 1'b1, 1'b1, 1'b0, d1};
    tbl[7]  = '{1'b1, d0, 1'b1, 1'b1, 1'b0, d0};
    tbl[8]  = '{1'b1, d0, 1'b1, 1'b1, 1'b0, d0};
    tbl[9]  = '{1'b1, d0, 1'b1, 1'b1, 1'b0, d0};
    tbl[10] = '{1'b0, d0, 1'b0, 1'b1, 1'b1, mk_marker(8'h09)};
    tbl[11] = '{1'b0, d0, 1'b1, 1'b0, 1'b1, mk_marker(8'h09)};

    @(negedge clk);
    do_reset(1'b0);

    // spelled-out first marker bytes
    chk("m0_literal", {1'b0, mk_marker(8'h00)}, {1'b0, 64'hFFDE973E_002168C1, 2'b01});

    for (int i = 0; i < 12; i++) begin
      logic rdy_seen;
      i_valid = tbl[i].v;
      #1;
      rdy_seen = rdy0;
      cycle(tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_rdy", i), {66'h0, rdy_seen}, {66'h0, tbl[i].rdy});
      chk($sformatf("tbl%0d_ov", i), {66'h0, ov0}, {66'h0, tbl[i].ov});
      chk($sformatf("tbl%0d_out", i), {fl0, od0}, {tbl[i].fl, tbl[i].od});
    end

    // zero-payload continuous stream: ready-low counts and period-3 BIP3
    @(negedge clk);
    do_reset(1'b0);
    lows0 = 0; lows1 = 0; nmk = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!rdy0) lows0++;
      if (!rdy1) lows1++;
      cycle(1'b1, d0);
      if (ov1 && fl1) begin
        if (nmk > 0) chk("p3_bip3", {59'h0, od1[33:26]}, {59'h0, 8'h18});
        nmk++;
      end
    end
    chk("ready_lows0", lows0, 4);
    chk("ready_lows1", lows1, 5);
    chk("p3_markers", nmk, 5);

    // random valid gaps and data
    for (int i = 0; i < 300; i++) begin
      r96 = {$urandom(), $urandom(), $urandom()};
      rd = r96[65:0];
      cycle($urandom_range(0, 2) != 0, rd);
    end

    // reset after 2 of 4 transfers, offered block discarded
    @(negedge clk);
    do_reset(1'b0);
    cycle(1'b0, d0);
    cycle(1'b1, d1);
    cycle(1'b1, d1);
    do_reset(1'b1);
    cycle(1'b1, d1);
    chk("post_rst_marker", {ov0, fl0, od0}, {2'b11, mk_marker(8'h00)});
    for (int i = 0; i < 5; i++) cycle(1'b1, d0);
    cycle(1'b0, d0);

    chk("q0_drained", exp_q0.size(), 0);
    chk("q1_drained", exp_q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
